// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, write-back, lookup, commit and flush signals of the reorder buffer
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif
interface reorder_buffer_if #(parameter int W = `ROB_WIDTH_BIT);
  logic          issue_valid;
  logic [1:0]    issue_type;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic [31:0]   issue_val;
  logic [31:0]   issue_pred_pc;
  logic [W-1:0]  issue_rob_id;
  logic          full;
  logic [4:0]    set_dep_reg_id;
  logic [W-1:0]  set_dep_rob_id;
  logic          alu_valid;
  logic [W-1:0]  alu_rob_id;
  logic [31:0]   alu_val;
  logic [31:0]   alu_addr;
  logic          lsb_valid;
  logic [W-1:0]  lsb_rob_id;
  logic [31:0]   lsb_val;
  logic [W-1:0]  get_rob_id1;
  logic [W-1:0]  get_rob_id2;
  logic          rob_value1_ready;
  logic          rob_value2_ready;
  logic [31:0]   rob_value1;
  logic [31:0]   rob_value2;
  logic [4:0]    set_reg_id;
  logic [31:0]   set_val;
  logic [W-1:0]  set_reg_on_rob_id;
  logic          commit_store;
  logic [W-1:0]  commit_rob_id;
  logic          rob_clear;
  logic [31:0]   clear_pc;
  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_pc,
           alu_valid, alu_rob_id, alu_val, alu_addr, lsb_valid, lsb_rob_id, lsb_val,
           get_rob_id1, get_rob_id2,
    output issue_rob_id, full, set_dep_reg_id, set_dep_rob_id, rob_value1_ready, rob_value2_ready,
           rob_value1, rob_value2, set_reg_id, set_val, set_reg_on_rob_id, commit_store,
           commit_rob_id, rob_clear, clear_pc
  );
  modport master (
    output issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_pc,
           alu_valid, alu_rob_id, alu_val, alu_addr, lsb_valid, lsb_rob_id, lsb_val,
           get_rob_id1, get_rob_id2,
    input  issue_rob_id, full, set_dep_reg_id, set_dep_rob_id, rob_value1_ready, rob_value2_ready,
           rob_value1, rob_value2, set_reg_id, set_val, set_reg_on_rob_id, commit_store,
           commit_rob_id, rob_clear, clear_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with rename, operand lookup and mispredict flush; define ROB_CDB_FORWARD_EN to forward same-cycle write-backs into lookups
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif
module reorder_buffer #(parameter int W = `ROB_WIDTH_BIT) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  reorder_buffer_if.slave bus
);
  localparam int N = 1 << W;
  localparam logic [1:0] STORE = 2'd1, BRANCH = 2'd2;
  logic [N-1:0] busy, rdy;
  logic [1:0] typ [N];
  logic [4:0] rd [N];
  logic [31:0] val [N], pred_pc [N], res_pc [N];
  logic [W-1:0] head, tail;
  logic [W:0] count;
  logic clear_q;
  logic [31:0] clear_pc_q;
  logic issue_ok, commit_ok, mispredict, reg_wr;
  function automatic logic [32:0] look(input logic [W-1:0] id);
    logic [32:0] r;
    r = {busy[id] && rdy[id], val[id]};
`ifdef ROB_CDB_FORWARD_EN
    if (busy[id] && !clear_q && bus.lsb_valid && bus.lsb_rob_id == id) r = {1'b1, bus.lsb_val};
    if (busy[id] && !clear_q && bus.alu_valid && bus.alu_rob_id == id) r = {1'b1, bus.alu_val};
`endif
    return r;
  endfunction
  // count only reaches N when full, so its top bit is the full flag
  assign bus.full = count[W];
  assign bus.rob_clear = clear_q;
  assign bus.clear_pc = clear_pc_q;
  assign bus.issue_rob_id = tail;
  assign bus.set_dep_rob_id = tail;
  assign {bus.rob_value1_ready, bus.rob_value1} = look(bus.get_rob_id1);
  assign {bus.rob_value2_ready, bus.rob_value2} = look(bus.get_rob_id2);
  always_comb begin
    issue_ok = bus.issue_valid && !count[W] && !clear_q && rdy_in;
    commit_ok = busy[head] && rdy[head] && rdy_in && !clear_q;
    mispredict = commit_ok && typ[head] == BRANCH && res_pc[head] != pred_pc[head];
    reg_wr = commit_ok && typ[head] != STORE;
    bus.set_dep_reg_id = issue_ok && bus.issue_type != STORE ? bus.issue_rd : 5'd0;
    bus.set_reg_id = reg_wr ? rd[head] : 5'd0;
    bus.set_val = reg_wr ? val[head] : 32'd0;
    bus.set_reg_on_rob_id = reg_wr ? head : '0;
    bus.commit_store = commit_ok && typ[head] == STORE;
    bus.commit_rob_id = commit_ok && typ[head] == STORE ? head : '0;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      busy <= '0;
      rdy <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      clear_q <= 1'b0;
      clear_pc_q <= '0;
      for (int i = 0; i < N; i++) begin
        typ[i] <= '0;
        rd[i] <= '0;
        val[i] <= '0;
        pred_pc[i] <= '0;
        res_pc[i] <= '0;
      end
    end else if (rdy_in) begin
      clear_q <= mispredict;
      if (mispredict) begin
        clear_pc_q <= res_pc[head];
        busy <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (!clear_q && bus.lsb_valid && busy[bus.lsb_rob_id]) begin
          rdy[bus.lsb_rob_id] <= 1'b1;
          val[bus.lsb_rob_id] <= bus.lsb_val;
        end
        // ALU is applied last so it wins a same-id collision with LSB
        if (!clear_q && bus.alu_valid && busy[bus.alu_rob_id]) begin
          rdy[bus.alu_rob_id] <= 1'b1;
          val[bus.alu_rob_id] <= bus.alu_val;
          res_pc[bus.alu_rob_id] <= bus.alu_addr;
        end
        if (commit_ok) begin
          busy[head] <= 1'b0;
          head <= head + W'(1);
        end
        // unresolved branches default to their prediction so they never flush spuriously
        if (issue_ok) begin
          busy[tail] <= 1'b1;
          rdy[tail] <= bus.issue_ready;
          typ[tail] <= bus.issue_type;
          rd[tail] <= bus.issue_rd;
          val[tail] <= bus.issue_val;
          pred_pc[tail] <= bus.issue_pred_pc;
          res_pc[tail] <= bus.issue_pred_pc;
          tail <= tail + W'(1);
        end
        count <= count + (W+1)'(issue_ok) - (W+1)'(commit_ok);
      end
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order RV32 core. It allocates one entry per issued instruction, announces the renaming to the register file, and collects results from the ALU and load/store write-back buses. It retires entries in program order, driving the register file's commit port and the LSB store-commit port. It answers the register file's two operand-value lookups and raises `rob_clear` on a branch/jump mispredict.

## Interface
- `ROB_WIDTH_BIT`, default `` `ROB_WIDTH_BIT `` from const.v: index width; depth = 2^ROB_WIDTH_BIT entries.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: state frozen while low.
- `issue_valid` in 1: allocate an entry this cycle.
- `issue_type` in 2: 0 REG (writes rd), 1 STORE, 2 BRANCH (may also write rd, e.g. JAL/JALR).
- `issue_rd` in 5: destination register; 0 = none.
- `issue_ready` in 1: result already known at issue (LUI/AUIPC).
- `issue_val` in 32: result when `issue_ready`.
- `issue_pred_pc` in 32: predicted next PC (BRANCH only).
- `issue_rob_id` out W: index the next issue receives (tail).
- `full` out 1: no free entry.
- `set_dep_reg_id` out 5: rename target to the register file; 0 = none.
- `set_dep_rob_id` out W: tail index paired with `set_dep_reg_id`.
- `alu_valid`, `alu_rob_id` (W), `alu_val` (32), `alu_addr` (32) in: ALU write-back; `alu_addr` = resolved next PC.
- `lsb_valid`, `lsb_rob_id` (W), `lsb_val` (32) in: load/store write-back.
- `get_rob_id1`, `get_rob_id2` in W: operand lookups from the register file.
- `rob_value1_ready`, `rob_value2_ready` out 1; `rob_value1`, `rob_value2` out 32: lookup answers.
- `set_reg_id` out 5, `set_val` out 32, `set_reg_on_rob_id` out W: register commit; `set_reg_id` = 0 means no write.
- `commit_store` out 1, `commit_rob_id` out W: store retire pulse to the LSB.
- `rob_clear` out 1: flush pulse to every unit.
- `clear_pc` out 32: fetch redirect target, valid while `rob_clear` is high.

## Operation
- Per-entry state: busy, ready, type, rd, val, pred_pc, res_pc. Pointers: head, tail, and count (W+1 bits).
- Issue is accepted when `issue_valid && !full && !rob_clear && rdy_in`.
  - On acceptance, the entry at tail is written and tail increments mod 2^W.
  - ready = `issue_ready`.
  - `issue_valid` while `full` is ignored. No entry is written and no rename is emitted.
- Rename outputs are combinational:
  - `set_dep_reg_id` = `issue_rd` when issue is accepted and type ≠ STORE, else 0.
  - `set_dep_rob_id` = tail.
- Write-back: on the edge, a busy entry at `alu_rob_id` or `lsb_rob_id` sets ready and stores the value.
  - ALU also stores `res_pc` = `alu_addr`.
  - Write-back to a non-busy entry is ignored.
  - If both buses hit the same id, ALU wins.
- Commit happens when the head entry is busy and ready, with `rdy_in` high and `rob_clear` low. Commit outputs are combinational that cycle:
  - REG, or BRANCH with rd ≠ 0: `set_reg_id` = rd, `set_val` = val, `set_reg_on_rob_id` = head.
  - STORE: `commit_store` = 1, `commit_rob_id` = head.
  - At the edge, the head entry clears busy and head increments.
  - At most one commit per cycle.
- Mispredict: a committing BRANCH with `res_pc` ≠ `pred_pc`.
  - Its rd write still commits that cycle.
  - At the same edge, all entries clear busy, head = tail = count = 0, `rob_clear` <= 1, `clear_pc` <= `res_pc`.
  - `rob_clear` lasts exactly one cycle. Issue and write-back are ignored during it.
- Lookup `k`: `rob_value{k}_ready` = busy && ready of entry `get_rob_id{k}`; `rob_value{k}` = its val.
- count updates by +1 on issue, −1 on commit, and is unchanged on simultaneous issue and commit. `full` = (count == 2^W).

## Timing
- Reset (asynchronous, immediate):
  - All entries not busy; head = tail = count = 0.
  - `rob_clear` = 0, `clear_pc` = 0, `full` = 0.
  - Every combinational output = 0, except `issue_rob_id` = 0 and `set_dep_rob_id` = 0.
  - Reset asserted mid-operation discards all in-flight entries.
- While `rdy_in` is low: no state change; `set_reg_id` = 0, `commit_store` = 0, `set_dep_reg_id` = 0.
- Latencies:
  - Issue at edge t → entry visible from cycle t+1.
  - Write-back at edge t → entry ready from cycle t+1.
  - Earliest commit of a ready entry is cycle t+1 after its issue edge t.
  - Mispredict commit in cycle c → `rob_clear` high in cycle c+1 only.
- Full boundary: `full` is registered state. A commit while full frees a slot that is usable the next cycle, not the same cycle. Tail and head wrap from 2^W−1 to 0.

## Configuration
- `ROB_CDB_FORWARD_EN` defined: lookups also match `alu_valid`/`lsb_valid` write-backs in the same cycle. ready = 1, and the value comes from the bus, with ALU priority.
- `ROB_CDB_FORWARD_EN` undefined: lookups see only stored entry state, so same-cycle write-backs appear one cycle later.

## Test plan
- Issue REG rd=5, not ready, into an empty buffer → same cycle `set_dep_reg_id`=5, `set_dep_rob_id`=0. ALU then writes id 0 val 0x1234 → next cycle `set_reg_id`=5, `set_val`=0x1234, `set_reg_on_rob_id`=0, head=1.
- Issue 2^W entries → `full`=1, and the next issue is ignored with `set_dep_reg_id`=0. Commit one → `full`=0 the following cycle; the next issue gets `issue_rob_id`=0 (wrap).
- BRANCH rd=1, `pred_pc`=0x104, ALU `alu_addr`=0x200 → at commit `set_reg_id`=1. Next cycle `rob_clear`=1 and `clear_pc`=0x200 for one cycle, with count=0 after.
- Lookup id 2 (busy, not ready) while `alu_valid` writes id 2 val 7 → with macro: `rob_value1_ready`=1, `rob_value1`=7 the same cycle. Without macro: 0 that cycle, 1/7 the next.
- Write-back id 1 before id 0 → no commit until id 0 is ready, then commits of id 0 and id 1 on consecutive cycles.
- After 3 issues, pulse `rst_in` between clock edges → `full`=0, `set_reg_id`=0, `rob_clear`=0 immediately. A following issue gets id 0.
